// File: rtl/peripheral_dbg_module_select_if.sv
// rtl/peripheral_dbg_module_select_if.sv - TAP and sub-module signal bundle for the debug module select
interface peripheral_dbg_module_select_if #(
    parameter int NUM_MODULES = 3
);
    logic                   debug_select_i;
    logic                   capture_dr_i;
    logic                   shift_dr_i;
    logic                   update_dr_i;
    logic                   tdi_i;
    logic [NUM_MODULES-1:0] module_tdo_i;
    logic [NUM_MODULES-1:0] module_select_o;
    logic                   select_err_o;
    logic                   tdo_o;

    modport master (
        output debug_select_i, capture_dr_i, shift_dr_i, update_dr_i, tdi_i, module_tdo_i,
        input  module_select_o, select_err_o, tdo_o
    );

    modport slave (
        input  debug_select_i, capture_dr_i, shift_dr_i, update_dr_i, tdi_i, module_tdo_i,
        output module_select_o, select_err_o, tdo_o
    );
endinterface

// File: rtl/peripheral_dbg_module_select.sv
// rtl/peripheral_dbg_module_select.sv - CRC-checked debug sub-module select and TDO mux
module peripheral_dbg_module_select #(
    parameter int MODULE_ID_LEN = 2,
    parameter int NUM_MODULES   = 3
) (
    input  logic tck_i,
    input  logic rst_i,
    peripheral_dbg_module_select_if.slave dbg
);
    localparam int HDR_LEN = 1 + MODULE_ID_LEN;
    localparam int CNT_MAX = HDR_LEN + 32;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [31:0] CRC_POLY = 32'h04C11DB7;

    logic [CNT_W-1:0]         bit_cnt;
    logic [31:0]              crc;
    logic [31:0]              rx_crc;
    logic [HDR_LEN-1:0]       header;
    logic [NUM_MODULES-1:0]   module_select;
    logic                     select_err;

    logic [31:0]              crc_next;
    logic [MODULE_ID_LEN-1:0] hdr_id;
    logic                     frame_valid;

    always_comb begin
        crc_next = {crc[30:0], 1'b0} ^ ((crc[31] ^ dbg.tdi_i) ? CRC_POLY : 32'h0);
    end

    always_comb begin
        hdr_id      = header[HDR_LEN-1:1];
        frame_valid = (bit_cnt == CNT_W'(CNT_MAX)) && (rx_crc == crc) &&
                      ({1'b0, hdr_id} < (MODULE_ID_LEN + 1)'(NUM_MODULES));
    end

    always_ff @(posedge tck_i) begin
        if (rst_i) begin
            bit_cnt       <= '0;
            crc           <= 32'hFFFFFFFF;
            rx_crc        <= '0;
            header        <= '0;
            module_select <= '0;
            select_err    <= 1'b0;
        end else if (dbg.debug_select_i) begin
            if (dbg.capture_dr_i) begin
                bit_cnt <= '0;
                crc     <= 32'hFFFFFFFF;
                header  <= '0;
            end else if (dbg.shift_dr_i) begin
                if (bit_cnt < CNT_W'(HDR_LEN)) begin
                    for (int i = 0; i < HDR_LEN; i++) begin
                        if (bit_cnt == CNT_W'(i)) begin
                            header[i] <= dbg.tdi_i;
                        end
                    end
                    crc <= crc_next;
                end else if (bit_cnt < CNT_W'(CNT_MAX)) begin
                    rx_crc <= {rx_crc[30:0], dbg.tdi_i};
                end
                // Saturate so trailing bits for other modules never disturb the frame.
                if (bit_cnt != CNT_W'(CNT_MAX)) begin
                    bit_cnt <= bit_cnt + 1'b1;
                end
            end else if (dbg.update_dr_i && header[0]) begin
                if (frame_valid) begin
                    module_select <= NUM_MODULES'(1) << hdr_id;
                    select_err    <= 1'b0;
                end else begin
                    select_err    <= 1'b1;
                end
            end
        end
    end

    assign dbg.module_select_o = module_select;
    assign dbg.select_err_o    = select_err;
    assign dbg.tdo_o           = |(module_select & dbg.module_tdo_i);
endmodule

// File: tb/tb_peripheral_dbg_module_select.sv
// tb/tb_peripheral_dbg_module_select.sv - scoreboard bench with frame-level reference model
module tb_peripheral_dbg_module_select;
    localparam int N = 3;

    logic tck = 1'b0;
    logic rst = 1'b0;
    always #5 tck = ~tck;

    peripheral_dbg_module_select_if #(.NUM_MODULES(N)) dbg ();

    peripheral_dbg_module_select #(.MODULE_ID_LEN(2), .NUM_MODULES(N)) dut (
        .tck_i (tck),
        .rst_i (rst),
        .dbg   (dbg)
    );

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [N-1:0] sel;
        logic         err;
    } exp_t;

    exp_t     exp_q[$];
    bit       mbits[$];
    bit       frame[$];
    logic [N-1:0] msel = '0;
    logic         merr = 1'b0;

    function automatic logic [31:0] crc_of(input bit b0, input bit b1, input bit b2);
        logic [31:0] c;
        bit          b[3];
        c = 32'hFFFFFFFF;
        b[0] = b0; b[1] = b1; b[2] = b2;
        for (int i = 0; i < 3; i++) begin
            if (c[31] != b[i]) c = (c << 1) ^ 32'h04C11DB7;
            else               c = c << 1;
        end
        return c;
    endfunction

    task automatic push_exp();
        exp_t e;
        e.sel = msel;
        e.err = merr;
        exp_q.push_back(e);
    endtask

    // A select frame is judged on the whole bit string shifted since capture.
    task automatic model_update(input bit ds);
        int          id;
        logic [31:0] rx;
        bit          ok;
        if (ds && mbits.size() > 0 && mbits[0]) begin
            ok = (mbits.size() >= 35);
            if (ok) begin
                id = int'(mbits[1]) + 2 * int'(mbits[2]);
                rx = '0;
                for (int i = 0; i < 32; i++) rx = {rx[30:0], mbits[3 + i]};
                ok = (rx == crc_of(mbits[0], mbits[1], mbits[2])) && (id < N);
            end
            if (ok) begin
                msel = N'(1) << id;
                merr = 1'b0;
            end else begin
                merr = 1'b1;
            end
        end
        push_exp();
    endtask

    task automatic step();
        @(negedge tck);
    endtask

    task automatic do_reset(input int ncyc);
        for (int i = 0; i < ncyc; i++) begin
            rst = 1'b1;
            msel = '0;
            merr = 1'b0;
            mbits.delete();
            push_exp();
            step();
        end
        rst = 1'b0;
    endtask

    task automatic build_frame(input bit flag, input int id, input logic [31:0] crc_xor, input int len);
        logic [31:0] c;
        bit b1, b2;
        b1 = id[0];
        b2 = id[1];
        c = crc_of(flag, b1, b2) ^ crc_xor;
        frame.delete();
        frame.push_back(flag);
        frame.push_back(b1);
        frame.push_back(b2);
        for (int i = 31; i >= 0; i--) frame.push_back(c[i]);
        while (frame.size() > len) void'(frame.pop_back());
        while (frame.size() < len) frame.push_back(bit'($urandom_range(0, 1)));
    endtask

    task automatic send(input bit ds, input bit upd, input int rst_pos);
        dbg.debug_select_i = ds;
        dbg.capture_dr_i   = 1'b1;
        if (ds) mbits.delete();
        step();
        dbg.capture_dr_i   = 1'b0;
        for (int i = 0; i < frame.size(); i++) begin
            if (i == rst_pos) begin
                dbg.shift_dr_i = 1'b0;
                do_reset(1);
                break;
            end
            dbg.shift_dr_i = 1'b1;
            dbg.tdi_i      = frame[i];
            if (ds && mbits.size() < 35) mbits.push_back(frame[i]);
            step();
        end
        dbg.shift_dr_i = 1'b0;
        dbg.tdi_i      = 1'b0;
        if (upd) begin
            dbg.update_dr_i = 1'b1;
            model_update(ds);
            step();
            dbg.update_dr_i = 1'b0;
        end
        dbg.debug_select_i = 1'b0;
        step();
    endtask

    // Monitor: every reset or update edge produces one expected state.
    always begin
        @(posedge tck);
        if (dbg.update_dr_i || rst) begin
            #2;
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL scoreboard_underflow: no expectation queued at %0t", $time);
            end else begin
                exp_t e;
                logic exp_tdo;
                e = exp_q.pop_front();
                exp_tdo = |(e.sel & dbg.module_tdo_i);
                checks++;
                if (dbg.module_select_o !== e.sel) begin
                    failures++;
                    $display("FAIL module_select: got %b expected %b at %0t", dbg.module_select_o, e.sel, $time);
                end
                checks++;
                if (dbg.select_err_o !== e.err) begin
                    failures++;
                    $display("FAIL select_err: got %b expected %b at %0t", dbg.select_err_o, e.err, $time);
                end
                checks++;
                if (dbg.tdo_o !== exp_tdo) begin
                    failures++;
                    $display("FAIL tdo: got %b expected %b (tdo_in %b) at %0t", dbg.tdo_o, exp_tdo, dbg.module_tdo_i, $time);
                end
            end
        end
    end

    initial begin
        int wait_cyc;
        dbg.debug_select_i = 1'b0;
        dbg.capture_dr_i   = 1'b0;
        dbg.shift_dr_i     = 1'b0;
        dbg.update_dr_i    = 1'b0;
        dbg.tdi_i          = 1'b0;
        dbg.module_tdo_i   = 3'b111;
        step();
        do_reset(3);

        dbg.module_tdo_i = 3'b100;
        build_frame(1'b1, 2, 32'h0, 35);          send(1'b1, 1'b1, -1);
        build_frame(1'b1, 2, 32'h1, 35);          send(1'b1, 1'b1, -1);
        build_frame(1'b1, 3, 32'h0, 35);          send(1'b1, 1'b1, -1);
        dbg.module_tdo_i = 3'b011;
        build_frame(1'b0, 1, 32'h0, 40);          send(1'b1, 1'b1, -1);
        build_frame(1'b1, 2, 32'h0, 20);          send(1'b1, 1'b1, -1);
        build_frame(1'b1, 0, 32'h0, 35);          send(1'b1, 1'b1, -1);
        build_frame(1'b1, 2, 32'h0, 20);          send(1'b0, 1'b1, -1);
        build_frame(1'b1, 1, 32'h0, 35);          send(1'b1, 1'b1, 10);
        dbg.module_tdo_i = 3'b111;
        build_frame(1'b1, 1, 32'h0, 35);          send(1'b1, 1'b1, -1);

        for (int it = 0; it < 60; it++) begin
            bit          flag;
            bit          ds;
            int          id;
            int          len;
            int          rpos;
            logic [31:0] cx;
            flag = ($urandom_range(0, 3) != 0);
            ds   = ($urandom_range(0, 5) != 0);
            id   = int'($urandom_range(0, 3));
            cx   = ($urandom_range(0, 3) == 0) ? (32'h1 << $urandom_range(0, 31)) : 32'h0;
            case ($urandom_range(0, 3))
                0:       len = int'($urandom_range(1, 34));
                1:       len = int'($urandom_range(36, 45));
                default: len = 35;
            endcase
            rpos = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 30)) : -1;
            dbg.module_tdo_i = N'($urandom_range(0, 7));
            build_frame(flag, id, cx, len);
            send(ds, 1'b1, rpos);
        end

        wait_cyc = 0;
        while (exp_q.size() != 0 && wait_cyc < 20) begin
            step();
            wait_cyc++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
